vga_sync_decoder: RTL and testbench

- Receive side of the VGA timing interface: consumes Horizontal/Vertical/picture from a VGA source and recovers X/Y pixel coordinates.
- Measures line/frame totals and active sizes; flags lock once timing is stable.
- Used at the capture/monitor end of a link and as a self-check loop on our own sync generator.

---
 rtl/vga_sync_decoder.sv | 237 +++++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: VGA receive-side timing decoder.
// Recovers X/Y pixel coordinates and measures line/frame geometry.
//
// Ports:
//   clock       pixel clock, all logic on posedge
//   reset       synchronous, active-high
//   Horizontal  hsync pin from source
//   Vertical    vsync pin from source
//   picture     active-video enable from source
//   X, Y        column/row within active area
//   active      X/Y valid (delayed picture)
//   line_start  one-cycle pulse on hs asserting edge
//   frame_start one-cycle pulse on vs asserting edge
//   h_total     clocks per line, last measured
//   v_total     lines per frame, last measured
//   h_active    picture-high clocks in last line
//   v_active    lines containing picture in last frame
//   locked      timing stable
module vga_sync_decoder #(
  parameter bit NEGATIVE   = 1'b1,
  parameter int LOCK_LINES = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Horizontal,
  input  logic        Vertical,
  input  logic        picture,
  output logic [15:0] X,
  output logic [15:0] Y,
  output logic        active,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] h_total,
  output logic [15:0] v_total,
  output logic [15:0] h_active,
  output logic [15:0] v_active,
  output logic        locked
);

  localparam logic [7:0]  LOCK_N = 8'(LOCK_LINES);
  localparam logic [15:0] TMO    = 16'(TIMEOUT);

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // stage 1: polarity-corrected pin capture
  logic s1_hs, s1_vs, s1_pic;
  // stage 2: previous stage-1 values
  logic s2_hs, s2_vs, s2_pic;

  logic hs_edge, vs_edge;
  logic pic_rise, pic_fall;

  // measurement / coordinate state
  logic [15:0] pcnt_q, pcnt_d;
  logic [15:0] lcnt_q, lcnt_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] ycnt_q, ycnt_d;
  logic [15:0] htot_q, htot_d;
  logic [15:0] vtot_q, vtot_d;
  logic [15:0] hact_q, hact_d;
  logic [15:0] vact_q, vact_d;
  logic [7:0]  hstb_q, hstb_d;
  logic        h_seen_q, h_seen_d;
  logic        v_seen_q, v_seen_d;
  logic        y_first_q, y_first_d;
  logic        v_match_q, v_match_d;
  logic        lock_q, lock_d;
  logic        act_q, ls_q, fs_q;
  logic        first_line;

  assign hs_edge  = s1_hs & ~s2_hs;
  assign vs_edge  = s1_vs & ~s2_vs;
  assign pic_rise = s1_pic & ~s2_pic;
  assign pic_fall = ~s1_pic & s2_pic;

  always_comb begin
    pcnt_d     = sat_inc(pcnt_q);
    lcnt_d     = lcnt_q;
    x_d        = x_q;
    y_d        = y_q;
    ycnt_d     = ycnt_q;
    htot_d     = htot_q;
    vtot_d     = vtot_q;
    hact_d     = hact_q;
    vact_d     = vact_q;
    hstb_d     = hstb_q;
    h_seen_d   = h_seen_q;
    v_seen_d   = v_seen_q;
    y_first_d  = y_first_q;
    v_match_d  = v_match_q;
    lock_d     = (hstb_q == LOCK_N) && v_match_q;
    first_line = y_first_q | vs_edge;

    if (hs_edge) begin
      pcnt_d   = '0;
      h_seen_d = 1'b1;
      lcnt_d   = sat_inc(lcnt_q);
      if (h_seen_q) begin
        htot_d = sat_inc(pcnt_q);
        if (sat_inc(pcnt_q) == htot_q) begin
          hstb_d = (hstb_q >= LOCK_N) ?
                   LOCK_N : hstb_q + 8'd1;
        end else begin
          hstb_d = '0;
        end
      end
    end

    if (vs_edge) begin
      if (v_seen_q) begin
        vtot_d = lcnt_q;
        vact_d = ycnt_q;
      end
      v_seen_d  = 1'b1;
      y_first_d = 1'b1;
      v_match_d = (lcnt_q == vtot_q) &&
                  (lcnt_q != 16'd0);
      // a coincident hs edge is line 1 of the new frame
      lcnt_d    = hs_edge ? 16'd1 : 16'd0;
    end

    if (pic_rise) begin
      x_d = '0;
      // vs in the same cycle makes this row 0 of the new frame
      if (first_line) begin
        y_d       = '0;
        y_first_d = 1'b0;
      end else begin
        y_d = sat_inc(y_q);
      end
      ycnt_d = sat_inc(y_d);
    end else if (s1_pic) begin
      x_d = sat_inc(x_q);
    end

    if (pic_fall) begin
      hact_d = sat_inc(x_q);
    end

    // lost hsync: forget stability, keep measured values
    if (!hs_edge && pcnt_q >= TMO) begin
      lock_d    = 1'b0;
      hstb_d    = '0;
      v_match_d = 1'b0;
      h_seen_d  = 1'b0;
      v_seen_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_pic    <= 1'b0;
      s2_hs     <= 1'b0;
      s2_vs     <= 1'b0;
      s2_pic    <= 1'b0;
      pcnt_q    <= '0;
      lcnt_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      ycnt_q    <= '0;
      htot_q    <= '0;
      vtot_q    <= '0;
      hact_q    <= '0;
      vact_q    <= '0;
      hstb_q    <= '0;
      h_seen_q  <= 1'b0;
      v_seen_q  <= 1'b0;
      y_first_q <= 1'b0;
      v_match_q <= 1'b0;
      lock_q    <= 1'b0;
      act_q     <= 1'b0;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      s1_hs     <= Horizontal ^ NEGATIVE;
      s1_vs     <= Vertical ^ NEGATIVE;
      s1_pic    <= picture;
      s2_hs     <= s1_hs;
      s2_vs     <= s1_vs;
      s2_pic    <= s1_pic;
      pcnt_q    <= pcnt_d;
      lcnt_q    <= lcnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      ycnt_q    <= ycnt_d;
      htot_q    <= htot_d;
      vtot_q    <= vtot_d;
      hact_q    <= hact_d;
      vact_q    <= vact_d;
      hstb_q    <= hstb_d;
      h_seen_q  <= h_seen_d;
      v_seen_q  <= v_seen_d;
      y_first_q <= y_first_d;
      v_match_q <= v_match_d;
      lock_q    <= lock_d;
      act_q     <= s1_pic;
      ls_q      <= hs_edge;
      fs_q      <= vs_edge;
    end
  end

  // output register stage
  always_ff @(posedge clock) begin
    if (reset) begin
      X           <= '0;
      Y           <= '0;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      h_total     <= '0;
      v_total     <= '0;
      h_active    <= '0;
      v_active    <= '0;
      locked      <= 1'b0;
    end else begin
      X           <= x_q;
      Y           <= y_q;
      active      <= act_q;
      line_start  <= ls_q;
      frame_start <= fs_q;
      h_total     <= htot_q;
      v_total     <= vtot_q;
      h_active    <= hact_q;
      v_active    <= vact_q;
      locked      <= lock_q;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: scoreboard bench for vga_sync_decoder.
// Compact timing: H 64/4/8/4 (80), V 24/1/2/3 (30).
module tb_vga_sync_decoder;

  localparam int HS = 8;
  localparam int HB = 4;
  localparam int HA = 64;
  localparam int HF = 4;
  localparam int HT = HS + HB + HA + HF;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VA = 24;
  localparam int VF = 1;
  localparam int VT = VS + VB + VA + VF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        Horizontal = 1'b1;
  logic        Vertical = 1'b1;
  logic        picture = 1'b0;
  logic [15:0] X, Y;
  logic        active, line_start, frame_start;
  logic [15:0] h_total, v_total, h_active, v_active;
  logic        locked;

  vga_sync_decoder #(
    .NEGATIVE(1'b1),
    .LOCK_LINES(4),
    .TIMEOUT(4096)
  ) dut (
    .clock(clock),
    .reset(reset),
    .Horizontal(Horizontal),
    .Vertical(Vertical),
    .picture(picture),
    .X(X),
    .Y(Y),
    .active(active),
    .line_start(line_start),
    .frame_start(frame_start),
    .h_total(h_total),
    .v_total(v_total),
    .h_active(h_active),
    .v_active(v_active),
    .locked(locked)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef enum int {
    K_LS, K_FS, K_HT, K_VT, K_HA,
    K_VA, K_LK, K_X, K_Y, K_ACT
  } kind_t;

  typedef struct {
    int due;
    int x;
    int y;
  } pix_t;

  typedef struct {
    int    due;
    kind_t k;
    int    v;
  } reg_t;

  pix_t pq[$];
  reg_t rq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // spec-level model of the measured registers
  bit h_seen_m = 0;
  bit v_seen_m = 0;
  int htot_m = 0;
  int vtot_m = 0;
  int vact_m = 0;
  int hact_m = 0;
  int last_len = 0;
  int frame_no = 0;

  // directed lock checks: frame, line, offset, value
  int lk_f [10] = '{1, 3, 4, 4,  4,  4,  4, 6, 7, 9};
  int lk_l [10] = '{0, 0, 0, 11, 11, 16, 18, 0, 0, 0};
  int lk_o [10] = '{3, 3, 3, 3,  4,  3,  3, 3, 3, 3};
  int lk_v [10] = '{0, 0, 1, 1,  0,  0,  1, 0, 1, 0};

  task automatic expect_at(input int due,
                           input kind_t k,
                           input int v);
    reg_t r;
    r.due = due;
    r.k = k;
    r.v = v;
    rq.push_back(r);
  endtask

  task automatic expect_zero(input int due);
    for (int k = 0; k < 10; k++)
      expect_at(due, kind_t'(k), 0);
  endtask

  task automatic tick(input bit h, input bit v,
                      input bit p, input int px,
                      input int py);
    pix_t e;
    Horizontal = ~h;
    Vertical = ~v;
    picture = p;
    if (p) begin
      e.due = cyc + 3;
      e.x = px;
      e.y = py;
      pq.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_line(input int l, input int fp,
                          input bit rst_here);
    int c0;
    bit vsl;
    bit pl;
    c0 = cyc;
    vsl = (l < VS);
    pl = (l >= VS + VB) && (l < VS + VB + VA);
    if (h_seen_m) htot_m = last_len;
    h_seen_m = 1;
    expect_at(c0 + 3, K_LS, 1);
    expect_at(c0 + 3, K_HT, htot_m);
    if (l == 0) begin
      if (v_seen_m) begin
        vtot_m = VT;
        vact_m = VA;
      end
      v_seen_m = 1;
      expect_at(c0 + 3, K_FS, 1);
      expect_at(c0 + 3, K_VT, vtot_m);
      expect_at(c0 + 3, K_VA, vact_m);
      expect_at(c0 + 3, K_HA, hact_m);
    end
    for (int j = 0; j < 10; j++)
      if (lk_f[j] == frame_no && lk_l[j] == l)
        expect_at(c0 + lk_o[j], K_LK, lk_v[j]);
    for (int i = 0; i < HS + HB + HA + fp; i++) begin
      if (rst_here && i == 40) begin
        reset = 1'b1;
        expect_zero(cyc + 1);
        h_seen_m = 0;
        v_seen_m = 0;
        htot_m = 0;
        vtot_m = 0;
        vact_m = 0;
        hact_m = 0;
      end
      tick(i < HS, vsl,
           pl && i >= HS + HB && i < HS + HB + HA,
           i - HS - HB, l - VS - VB);
      reset = 1'b0;
    end
    last_len = HS + HB + HA + fp;
    if (pl) hact_m = HA;
  endtask

  task automatic run_frame(input bit shorten,
                           input bit do_rst);
    frame_no++;
    for (int l = 0; l < VT; l++)
      run_line(l,
               (shorten && l == 10) ? HF - 1 : HF,
               do_rst && l == VT - 1);
  endtask

  function automatic int dut_val(input kind_t k);
    case (k)
      K_LS:    return int'(line_start);
      K_FS:    return int'(frame_start);
      K_HT:    return int'(h_total);
      K_VT:    return int'(v_total);
      K_HA:    return int'(h_active);
      K_VA:    return int'(v_active);
      K_LK:    return int'(locked);
      K_X:     return int'(X);
      K_Y:     return int'(Y);
      default: return int'(active);
    endcase
  endfunction

  always @(negedge clock) begin
    int i;
    int got;
    while (pq.size() > 0 && pq[0].due < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pixel_missing cyc=%0d: active=0, want X=%0d Y=%0d",
               cyc, pq[0].x, pq[0].y);
      void'(pq.pop_front());
    end
    if (active) begin
      n_cmp++;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        if (int'(X) != pq[0].x || int'(Y) != pq[0].y) begin
          n_bad++;
          $display("FAIL pixel cyc=%0d: got X=%0d Y=%0d, want X=%0d Y=%0d",
                   cyc, X, Y, pq[0].x, pq[0].y);
        end
        void'(pq.pop_front());
      end else begin
        n_bad++;
        $display("FAIL pixel_extra cyc=%0d: got active=1 X=%0d Y=%0d, want active=0",
                 cyc, X, Y);
      end
    end
    i = 0;
    while (i < rq.size()) begin
      if (rq[i].due <= cyc) begin
        n_cmp++;
        got = dut_val(rq[i].k);
        if (rq[i].due < cyc || got != rq[i].v) begin
          n_bad++;
          $display("FAIL %s due=%0d cyc=%0d: got %0d, want %0d",
                   rq[i].k.name(), rq[i].due, cyc, got, rq[i].v);
        end
        rq.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    int g;
    @(posedge clock);
    #1;
    expect_zero(cyc + 1);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) tick(0, 0, 0, 0, 0);
    run_frame(0, 0);
    run_frame(0, 0);
    run_frame(0, 0);
    run_frame(1, 0);
    run_frame(0, 0);
    g = cyc;
    expect_at(g + 3000, K_LK, 1);
    expect_at(g + 4999, K_LK, 0);
    expect_at(g + 4999, K_HT, HT);
    repeat (5000) tick(0, 0, 0, 0, 0);
    h_seen_m = 0;
    v_seen_m = 0;
    run_frame(0, 0);
    run_frame(0, 0);
    run_frame(0, 1);
    run_frame(0, 0);
    run_frame(0, 0);
    repeat (10) tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (pq.size() != 0 || rq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pixels %0d regs pending, want 0",
               pq.size(), rq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
